// File: rtl/seg_p2s_ctrl.sv
// Serial sequencer for the eight-digit seven-segment display chain.
// Shifts a captured 64-bit segment image MSB-first, strobes the latch, and runs the refresh and blink timers.
module seg_p2s_ctrl #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned REFRESH   = 50000,
   parameter int unsigned FLASH_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] seg_txt,
   input  logic        start,
   input  logic        auto_en,
   output logic        busy,
   output logic        done,
   output logic        s_clk,
   output logic        s_dat,
   output logic        s_clr_n,
   output logic        s_en,
   output logic        flash
);

   localparam int unsigned PH_W = $clog2(CLK_DIV + 1);
   localparam int unsigned RF_W = $clog2(REFRESH);
   localparam int unsigned FL_W = $clog2(FLASH_DIV + 1);

   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

   state_t            r_state;
   logic [PH_W-1:0]   r_phase;
   logic [6:0]        r_bitcnt;
   logic [63:0]       r_shreg;
   logic              r_pend;
   logic [RF_W-1:0]   r_ref;
   logic [FL_W-1:0]   r_flcnt;

   logic w_tick;
   logic w_new_req;
   logic w_req;
   logic w_ph_end;

   assign w_tick    = (r_ref == RF_W'(REFRESH - 1));
   assign w_new_req = start | (w_tick & auto_en);
   assign w_req     = w_new_req | r_pend;
   assign w_ph_end  = (r_phase == PH_W'(CLK_DIV - 1));

   // Free-running refresh timer, independent of the frame state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ref <= '0;
      end else if (w_tick) begin
         r_ref <= '0;
      end else begin
         r_ref <= r_ref + 1'b1;
      end
   end

   // Blink square wave for the decoder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flcnt <= '0;
         flash   <= 1'b1;
      end else if (r_flcnt == FL_W'(FLASH_DIV - 1)) begin
         r_flcnt <= '0;
         flash   <= ~flash;
      end else begin
         r_flcnt <= r_flcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_clr_n <= 1'b0;
      end else begin
         s_clr_n <= 1'b1;
      end
   end

   // Frame sequencer; pend coalesces any requests that arrive while a frame runs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_phase  <= '0;
         r_bitcnt <= '0;
         r_shreg  <= '0;
         r_pend   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         s_clk    <= 1'b0;
         s_dat    <= 1'b0;
         s_en     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_state  <= SHIFT_LO;
                  r_shreg  <= seg_txt;
                  r_pend   <= 1'b0;
                  r_bitcnt <= '0;
                  r_phase  <= '0;
                  busy     <= 1'b1;
                  s_clk    <= 1'b0;
                  s_dat    <= seg_txt[63];
               end
            end
            SHIFT_LO: begin
               if (w_ph_end) begin
                  r_phase <= '0;
                  r_state <= SHIFT_HI;
                  s_clk   <= 1'b1;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            SHIFT_HI: begin
               if (w_ph_end) begin
                  r_phase  <= '0;
                  r_shreg  <= {r_shreg[62:0], 1'b0};
                  r_bitcnt <= r_bitcnt + 7'd1;
                  s_clk    <= 1'b0;
                  if (r_bitcnt == 7'd63) begin
                     r_state <= LATCH;
                     s_en    <= 1'b1;
                     s_dat   <= 1'b0;
                  end else begin
                     r_state <= SHIFT_LO;
                     s_dat   <= r_shreg[62];
                  end
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            LATCH: begin
               if (w_ph_end) begin
                  r_phase <= '0;
                  r_state <= IDLE;
                  s_en    <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
         if (r_state != IDLE && w_new_req) begin
            r_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_p2s_ctrl.sv
// Randomized bench for seg_p2s_ctrl against an acceptance-time reference model.
// Expected outputs are derived from the offset between the current edge and the last frame acceptance.
module tb_seg_p2s_ctrl;

   localparam int CLK_DIV   = 2;
   localparam int REFRESH   = 300;
   localparam int FLASH_DIV = 4;
   localparam int SHIFT_LEN = 128 * CLK_DIV;
   localparam int FRAME     = 129 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] seg_txt;
   logic        start;
   logic        auto_en;
   logic        busy, done, s_clk, s_dat, s_clr_n, s_en, flash;

   seg_p2s_ctrl #(
      .CLK_DIV   (CLK_DIV),
      .REFRESH   (REFRESH),
      .FLASH_DIV (FLASH_DIV)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .seg_txt (seg_txt),
      .start   (start),
      .auto_en (auto_en),
      .busy    (busy),
      .done    (done),
      .s_clk   (s_clk),
      .s_dat   (s_dat),
      .s_clr_n (s_clr_n),
      .s_en    (s_en),
      .flash   (flash)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Bits seen by the external chain on each serial clock rise.
   logic [63:0] cap = '0;
   always @(posedge s_clk) cap <= {cap[62:0], s_dat};

   // Reference model: edges since reset, last acceptance edge, captured image, pending request.
   int          m_e;
   int          m_k;
   bit          m_act;
   bit          m_pend;
   logic [63:0] m_data;

   task automatic model_reset();
      m_e = 0; m_k = 0; m_act = 0; m_pend = 0; m_data = '0;
   endtask

   task automatic model_edge();
      bit tick, req_new, idle_before;
      m_e++;
      tick        = (m_e % REFRESH) == 0;
      req_new     = start || (tick && auto_en);
      idle_before = !m_act || (m_e - 1 - m_k >= FRAME);
      if (idle_before && (req_new || m_pend)) begin
         m_k = m_e; m_data = seg_txt; m_act = 1; m_pend = 0;
      end else if (!idle_before && req_new) begin
         m_pend = 1;
      end
   endtask

   task automatic check_outputs();
      int   d;
      logic eb, ed, ec, edat, een;
      eb = 0; ed = 0; ec = 0; edat = 0; een = 0;
      if (m_act && (m_e - m_k <= FRAME)) begin
         d = m_e - m_k;
         if (d < FRAME) eb = 1;
         if (d < SHIFT_LEN) begin
            ec   = ((d / CLK_DIV) % 2) == 1;
            edat = m_data[63 - d / (2 * CLK_DIV)];
         end else if (d < FRAME) begin
            een = 1;
         end else begin
            ed = 1;
         end
      end
      check("busy", busy, eb);
      check("done", done, ed);
      check("s_clk", s_clk, ec);
      check("s_dat", s_dat, edat);
      check("s_en", s_en, een);
      check("s_clr_n", s_clr_n, (m_e >= 1) ? 1'b1 : 1'b0);
      check("flash", flash, ((m_e / FLASH_DIV) % 2 == 0) ? 1'b1 : 1'b0);
      if (ed) check("frame_data", cap, m_data);
   endtask

   task automatic cycle(input logic st, input logic ae, input logic [63:0] sg);
      start = st; auto_en = ae; seg_txt = sg;
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset(input int hold);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      for (int i = 0; i < hold; i++) cycle(1'b0, 1'b0, 64'h0);
      rst_n = 1'b1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      int lat, n_en, n_busy;
      int t3 [3];
      logic ae;
      rst_n = 1'b1; start = 1'b0; auto_en = 1'b0; seg_txt = '0;
      model_reset();
      #2;
      do_reset(2);

      // Directed frame with the reference vector and exact latencies.
      lat = -1; n_en = 0; n_busy = 0;
      for (int j = 0; j < 300; j++) begin
         cycle(j == 0, 1'b0, (j == 0) ? 64'hA5C3_0F00_FFFF_0001 : rnd64());
         if (done === 1'b1 && lat < 0) lat = j;
         if (s_en === 1'b1) n_en++;
         if (busy === 1'b1) n_busy++;
      end
      check("done_latency", 64'(lat), 64'(FRAME));
      check("s_en_cycles", 64'(n_en), 64'(CLK_DIV));
      check("busy_cycles", 64'(n_busy), 64'(FRAME));

      // Three starts while busy coalesce into one extra frame.
      t3[0] = 10 + $urandom_range(0, 60);
      t3[1] = 80 + $urandom_range(0, 80);
      t3[2] = 170 + $urandom_range(0, 87);
      for (int j = 0; j < 700; j++) begin
         cycle(j == 0 || j == t3[0] || j == t3[1] || j == t3[2], 1'b0, rnd64());
      end

      // Auto refresh only, then disabled.
      for (int j = 0; j < 1500; j++) cycle(1'b0, 1'b1, rnd64());
      for (int j = 0; j < 600; j++) cycle(1'b0, 1'b0, rnd64());

      // Reset around bit 30 of a frame.
      cycle(1'b1, 1'b0, rnd64());
      for (int j = 0; j < 121; j++) cycle(1'b0, 1'b0, rnd64());
      do_reset(3);
      for (int j = 0; j < 20; j++) cycle(1'b0, 1'b0, rnd64());

      // Mixed random traffic.
      ae = 1'b1;
      for (int j = 0; j < 4000; j++) begin
         if ($urandom_range(0, 499) == 0) ae = ~ae;
         cycle($urandom_range(0, 149) == 0, ae, rnd64());
      end
      for (int j = 0; j < 400; j++) cycle(1'b0, 1'b0, rnd64());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
